mul_err_stats: RTL and testbench

- Downstream statistics stage for the 8x8 approximate multipliers (ERCM8_x, Dadda family).
- Accepts each operand pair with the approximate product the multiplier produced, and recomputes the exact product internally.
- Accumulates error metrics in hardware over a programmed number of samples: error count, signed and absolute error-distance sums, and max absolute error.
- Host or bench derives ER, MED and MNED from the outputs by division, which replaces software-side metric collection.

---
 rtl/mul_err_stats.sv | 87 ++++++++
 tb/tb_mul_err_stats.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_err_stats.sv
// mul_err_stats: accumulates error statistics of an approximate multiplier against the exact product.
module mul_err_stats #(
   parameter int W_IN  = 8,
   parameter int CNT_W = 16,
   parameter int ACC_W = 40
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     n_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W_IN-1:0]      a,
   input  logic [W_IN-1:0]      b,
   input  logic [2*W_IN-1:0]    apprx,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     sample_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [ACC_W-1:0]     sum_abs_ed,
   output logic [ACC_W-1:0]     sum_ed,
   output logic [2*W_IN-1:0]    max_abs_ed
);
   localparam int PW = 2*W_IN;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
   logic [1:0]        state;
   logic [CNT_W-1:0]  target, acc_cnt;
   logic              s1_v, accept, start_ok, ed_ovf;
   logic [PW-1:0]     s1_exact, s1_apprx, abs_d;
   logic signed [PW:0] diff;
   logic [ACC_W:0]    abs_sum, ed_sum;
   assign in_ready = state == RUN && acc_cnt < target;
   assign accept   = in_valid && in_ready;
   assign start_ok = start && (state == IDLE || state == DONE);
   assign busy     = state == RUN || state == DRAIN;
   assign done     = state == DONE;
   // Sums are formed one bit wider so overflow is visible before clamping.
   always_comb begin
      diff    = $signed({1'b0, s1_exact}) - $signed({1'b0, s1_apprx});
      abs_d   = PW'(diff[PW] ? -diff : diff);
      abs_sum = {1'b0, sum_abs_ed} + {{(ACC_W+1-PW){1'b0}}, abs_d};
      ed_sum  = {sum_ed[ACC_W-1], sum_ed} + {{(ACC_W-PW){diff[PW]}}, diff};
      ed_ovf  = ed_sum[ACC_W] ^ ed_sum[ACC_W-1];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         target     <= '0;
         acc_cnt    <= '0;
         s1_v       <= 1'b0;
         s1_exact   <= '0;
         s1_apprx   <= '0;
         sample_cnt <= '0;
         err_cnt    <= '0;
         sum_abs_ed <= '0;
         sum_ed     <= '0;
         max_abs_ed <= '0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_exact <= PW'(a) * PW'(b);
            s1_apprx <= apprx;
         end
         if (start_ok) begin
            target     <= n_samples;
            acc_cnt    <= '0;
            state      <= n_samples != '0 ? RUN : DONE;
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_abs_ed <= '0;
            sum_ed     <= '0;
            max_abs_ed <= '0;
         end else begin
            if (accept) acc_cnt <= acc_cnt + 1'b1;
            if (accept && acc_cnt + 1'b1 == target) state <= DRAIN;
            if (state == DRAIN && !s1_v) state <= DONE;
            if (s1_v) begin
               sample_cnt <= sample_cnt + 1'b1;
               err_cnt    <= err_cnt + CNT_W'(diff != '0);
               sum_abs_ed <= abs_sum[ACC_W] ? '1 : abs_sum[ACC_W-1:0];
               sum_ed     <= ed_ovf ? {ed_sum[ACC_W], {(ACC_W-1){~ed_sum[ACC_W]}}} : ed_sum[ACC_W-1:0];
               max_abs_ed <= abs_d > max_abs_ed ? abs_d : max_abs_ed;
            end
         end
      end
   end
endmodule

// File: tb/tb_mul_err_stats.sv
// tb_mul_err_stats: table vectors, directed corner sequences and a scoreboarded random run.
module tb_mul_err_stats;
   logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
   logic [15:0] n_samples = 0, apprx = 0;
   logic [7:0]  a = 0, b = 0;
   logic in_ready, busy, done, in_ready2, busy2, done2;
   logic [15:0] sample_cnt, err_cnt, max_abs_ed, sc2, ec2, mx2;
   logic [39:0] sum_abs_ed, sum_ed;
   logic [16:0] sa2, se2;
   typedef struct {longint cnt, err, sabs, sed, mx;} st_t;
   typedef struct {logic [7:0] a, b; logic [15:0] p; longint ab, ed;} vec_t;
   st_t q[$];
   st_t m;
   int total = 0, bad = 0;
   logic [15:0] prev_cnt = 0;
   localparam longint MAXA = (longint'(1) << 40) - 1;
   localparam longint MAXS = (longint'(1) << 39) - 1;

   mul_err_stats dut (.clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .apprx(apprx), .busy(busy),
      .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_abs_ed(sum_abs_ed),
      .sum_ed(sum_ed), .max_abs_ed(max_abs_ed));
   mul_err_stats #(.ACC_W(17)) dut2 (.clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .apprx(apprx), .busy(busy2),
      .done(done2), .sample_cnt(sc2), .err_cnt(ec2), .sum_abs_ed(sa2), .sum_ed(se2),
      .max_abs_ed(mx2));

   always #5 clk = ~clk;
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic void model(input logic [7:0] x, y, input logic [15:0] p);
      longint d, ad;
      d = longint'(x) * longint'(y) - longint'(p);
      ad = d < 0 ? -d : d;
      m.cnt++;
      m.err += (d != 0) ? 1 : 0;
      m.sabs = m.sabs + ad > MAXA ? MAXA : m.sabs + ad;
      m.sed = m.sed + d > MAXS ? MAXS : (m.sed + d < -MAXS - 1 ? -MAXS - 1 : m.sed + d);
      m.mx = ad > m.mx ? ad : m.mx;
      q.push_back(m);
   endfunction

   always @(negedge clk) begin
      st_t e;
      if (rst_n && sample_cnt != prev_cnt && sample_cnt != 0) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got sample_cnt %0d expected no output", sample_cnt);
         end else begin
            e = q.pop_front();
            if (sample_cnt != 16'(e.cnt) || err_cnt != 16'(e.err) || sum_abs_ed != 40'(e.sabs)
                || sum_ed != 40'(e.sed) || max_abs_ed != 16'(e.mx)) begin
               bad++;
               $display("FAIL sb_stats: got cnt=%0d err=%0d sabs=%0d sed=%0d max=%0d expected %0d %0d %0d %0d %0d",
                  sample_cnt, err_cnt, sum_abs_ed, $signed(sum_ed), max_abs_ed,
                  e.cnt, e.err, e.sabs, e.sed, e.mx);
            end
         end
      end
      prev_cnt <= sample_cnt;
   end

   task automatic cyc(input logic v, input logic [7:0] x, y, input logic [15:0] p,
                      input logic st, output logic acc);
      in_valid = v; a = x; b = y; apprx = p; start = st;
      #1;
      acc = v && in_ready;
      if (acc) model(x, y, p);
      @(negedge clk);
      in_valid = 0; start = 0;
   endtask

   task automatic go(input logic [15:0] n);
      n_samples = n; start = 1; in_valid = 1;
      m = '{default: 0};
      #1;
      chk("ready_at_start", in_ready, 0);
      @(negedge clk);
      start = 0; in_valid = 0;
   endtask

   task automatic feed(input logic [7:0] x, y, input logic [15:0] p);
      logic acc = 0;
      for (int k = 0; k < 20 && !acc; k++) cyc(1, x, y, p, 0, acc);
      chk("feed_accept", acc, 1);
   endtask

   task automatic wait_done(input int lim);
      for (int k = 0; k < lim && !done; k++) @(negedge clk);
      chk("done_reached", done, 1);
   endtask

   initial begin
      vec_t tbl[9];
      logic acc;
      int nacc;
      logic [15:0] ex, p;
      tbl = '{'{8'd10, 8'd10, 16'd100, 0, 0}, '{8'd255, 8'd255, 16'd65000, 25, 25},
              '{8'd3, 8'd4, 16'd15, 3, -3}, '{8'd0, 8'd0, 16'd65535, 65535, -65535},
              '{8'd255, 8'd255, 16'd0, 65025, 65025}, '{8'd1, 8'd1, 16'd0, 1, 1},
              '{8'd200, 8'd3, 16'd600, 0, 0}, '{8'd17, 8'd19, 16'd300, 23, 23},
              '{8'd128, 8'd2, 16'd257, 1, -1}};
      repeat (2) @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", sample_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_sabs", sum_abs_ed, 0);
      chk("rst_sed", sum_ed, 0);
      chk("rst_max", max_abs_ed, 0);
      rst_n = 1;
      @(negedge clk);
      // one-sample runs per table vector
      for (int i = 0; i < 9; i++) begin
         go(1);
         feed(tbl[i].a, tbl[i].b, tbl[i].p);
         wait_done(10);
         chk("tbl_cnt", sample_cnt, 1);
         chk("tbl_err", err_cnt, tbl[i].ab != 0 ? 1 : 0);
         chk("tbl_sabs", sum_abs_ed, tbl[i].ab);
         chk("tbl_sed", $signed(sum_ed), tbl[i].ed);
         chk("tbl_max", max_abs_ed, tbl[i].ab);
      end
      go(3);
      feed(10, 10, 100);
      feed(255, 255, 65000);
      feed(3, 4, 15);
      wait_done(10);
      chk("dir_cnt", sample_cnt, 3);
      chk("dir_err", err_cnt, 2);
      chk("dir_sabs", sum_abs_ed, 28);
      chk("dir_sed", $signed(sum_ed), 22);
      chk("dir_max", max_abs_ed, 25);
      go(0);
      chk("zero_done", done, 1);
      chk("zero_ready", in_ready, 0);
      chk("zero_cnt", sample_cnt, 0);
      chk("zero_sabs", sum_abs_ed, 0);
      chk("zero_max", max_abs_ed, 0);
      go(2);
      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'(i + 5), 8'(i + 9), 16'(i * 7), 0, acc);
         if (i == 2) chk("hold_ready_3rd", acc, 0);
         nacc += acc ? 1 : 0;
      end
      chk("hold_accepted", nacc, 2);
      wait_done(10);
      chk("hold_cnt", sample_cnt, 2);
      go(3);
      for (int i = 0; i < 5; i++) cyc(i % 2 == 0, 8'(i + 3), 8'd7, 16'd20, i == 1, acc);
      chk("tog_done_c1", done, 0);
      chk("tog_busy_c1", busy, 1);
      @(negedge clk);
      chk("tog_done_c2", done, 0);
      @(negedge clk);
      chk("tog_done_c3", done, 1);
      chk("tog_cnt", sample_cnt, 3);
      go(10);
      for (int i = 0; i < 5; i++) feed(8'(i + 1), 8'd3, 16'd1);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", sample_cnt, 0);
      chk("mid_rst_sabs", sum_abs_ed, 0);
      chk("mid_rst_sed", sum_ed, 0);
      chk("mid_rst_max", max_abs_ed, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_done", done, 0);
      go(2);
      feed(9, 9, 80);
      feed(2, 2, 4);
      wait_done(10);
      chk("post_rst_cnt", sample_cnt, 2);
      chk("post_rst_err", err_cnt, 1);
      go(4);
      repeat (4) feed(0, 0, 16'hFFFF);
      wait_done(10);
      chk("sat_abs", sa2, 131071);
      chk("sat_neg", se2, 65536);
      chk("sat_max", mx2, 65535);
      go(2);
      repeat (2) feed(255, 255, 0);
      wait_done(10);
      chk("sat_pos", se2, 65535);
      chk("sat_abs_nosat", sa2, 130050);
      go(10000);
      nacc = 0;
      for (int k = 0; k < 40000 && nacc < 10000; k++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         ex = 16'(a) * 16'(b);
         case ($urandom_range(0, 2))
            0: p = ex;
            1: p = ex + 16'($urandom_range(0, 64)) - 16'd32;
            default: p = 16'($urandom);
         endcase
         cyc($urandom_range(0, 3) != 0, a, b, p, 0, acc);
         nacc += acc ? 1 : 0;
      end
      wait_done(10);
      chk("rnd_cnt", sample_cnt, 10000);
      chk("rnd_err", err_cnt, m.err);
      chk("rnd_sabs", sum_abs_ed, m.sabs);
      chk("rnd_sed", $signed(sum_ed), m.sed);
      chk("rnd_max", max_abs_ed, m.mx);
      chk("rnd_sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
